// File: rtl/decode_issue_ctrl_pkg.sv
// Shared definitions for the decode/issue sequencer: sizes, opcode[6:2]
// class codes, FSM state encoding and the register-use decode helper.
package decode_issue_ctrl_pkg;

  localparam int XLEN    = 32;
  localparam int NREGS   = 32;
  localparam int RIDX_W  = $clog2(NREGS);
  localparam int STALL_W = 16;

  // opcode[6:2] major classes
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_OP_FP  = 5'b10100;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  typedef struct packed {
    logic use_rs1;
    logic use_rs2;
    logic use_rd;
  } reg_use_t;

  // Which register fields an instruction class actually reads/writes.
  // Unknown opcodes use nothing, so they never stall and never reserve rd.
  function automatic reg_use_t decode_use(input logic [4:0] opc);
    reg_use_t u;
    u = '0;
    case (opc)
      OPC_OP, OPC_OP_FP:             u = '{use_rs1: 1'b1, use_rs2: 1'b1, use_rd: 1'b1};
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: u = '{use_rs1: 1'b1, use_rs2: 1'b0, use_rd: 1'b1};
      OPC_STORE, OPC_BRANCH:         u = '{use_rs1: 1'b1, use_rs2: 1'b1, use_rd: 1'b0};
      OPC_LUI, OPC_AUIPC, OPC_JAL:   u = '{use_rs1: 1'b0, use_rs2: 1'b0, use_rd: 1'b1};
      default:                       u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/decode_issue_ctrl_if.sv
// Fetch / execute / writeback signal bundle for the decode/issue sequencer.
// slave: the sequencer side. master: the surrounding pipeline side.
interface decode_issue_ctrl_if
  import decode_issue_ctrl_pkg::*;
();
  logic              if_valid;
  logic [XLEN-1:0]   if_instr;
  logic              if_ready;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_instr;
  logic              ex_ready;
  logic              wb_valid;
  logic [RIDX_W-1:0] wb_rd;
  logic              flush;

  modport slave (
    input  if_valid, if_instr, ex_ready, wb_valid, wb_rd, flush,
    output if_ready, ex_valid, ex_instr
  );

  modport master (
    output if_valid, if_instr, ex_ready, wb_valid, wb_rd, flush,
    input  if_ready, ex_valid, ex_instr
  );
endinterface

// File: rtl/decode_issue_ctrl_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// writer issues, cleared at writeback. x0 is never tracked.
module issue_scoreboard #(
  parameter int NREGS  = 32,
  parameter int RIDX_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [RIDX_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [RIDX_W-1:0] clr_idx,
  input  logic [RIDX_W-1:0] rs1_idx,
  input  logic [RIDX_W-1:0] rs2_idx,
  input  logic [RIDX_W-1:0] rd_idx,
  output logic              rs1_pend,
  output logic              rs2_pend,
  output logic              rd_pend,
  output logic [NREGS-1:0]  pend_next
);

  logic [NREGS-1:0] pend_q;

  // Next pending vector; set is applied after clear so a new writer stays outstanding.
  always_comb begin
    pend_next = pend_q;
    for (int i = 1; i < NREGS; i++) begin
      if (clr_en && clr_idx == RIDX_W'(i)) pend_next[i] = 1'b0;
      if (set_en && set_idx == RIDX_W'(i)) pend_next[i] = 1'b1;
    end
    pend_next[0] = 1'b0;
  end

  // Pending register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_next;
  end

  assign rs1_pend = pend_q[rs1_idx];
  assign rs2_pend = pend_q[rs2_idx];
  assign rd_pend  = pend_q[rd_idx];

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode/issue sequencer: buffers one fetched instruction, checks RAW/WAW
// against the pending-write scoreboard and hands it to execute when clear.
// Optional build macro ISSUE_BYPASS_EN: a writeback in the current cycle
// masks its scoreboard bit so a dependent instruction issues in that cycle.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no instruction buffered
// ST_HOLD  | instruction buffered, no hazard against scoreboard
// ST_STALL | instruction buffered, waiting on a pending write
module decode_issue_ctrl
  import decode_issue_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  decode_issue_ctrl_if.slave bus,
  output logic [STALL_W-1:0] stall_cnt
);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   instr_q;
  logic [XLEN-1:0]   next_instr;
  logic [RIDX_W-1:0] rs1, rs2, rd;
  reg_use_t          cur_use, next_use;
  logic              rs1_pend, rs2_pend, rd_pend;
  logic [NREGS-1:0]  pend_next;
  logic              byp1, byp2, bypd;
  logic              buf_valid, hazard, issue, accept, set_en, clr_en, next_hz;

  assign buf_valid = (state_q != ST_EMPTY);
  assign rs1       = instr_q[19:15];
  assign rs2       = instr_q[24:20];
  assign rd        = instr_q[11:7];
  assign cur_use   = decode_use(instr_q[6:2]);

`ifdef ISSUE_BYPASS_EN
  assign byp1 = bus.wb_valid && (bus.wb_rd == rs1);
  assign byp2 = bus.wb_valid && (bus.wb_rd == rs2);
  assign bypd = bus.wb_valid && (bus.wb_rd == rd);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
  assign bypd = 1'b0;
`endif

  assign hazard = (cur_use.use_rs1 && rs1 != '0 && rs1_pend && !byp1) ||
                  (cur_use.use_rs2 && rs2 != '0 && rs2_pend && !byp2) ||
                  (cur_use.use_rd  && rd  != '0 && rd_pend  && !bypd);

  assign bus.ex_valid = buf_valid && !hazard && !bus.flush;
  assign bus.ex_instr = instr_q;
  assign issue        = bus.ex_valid && bus.ex_ready;
  assign bus.if_ready = !bus.flush && (state_q == ST_EMPTY || issue);
  assign accept       = bus.if_valid && bus.if_ready;

  assign set_en = issue && cur_use.use_rd && rd != '0;
  assign clr_en = bus.wb_valid && bus.wb_rd != '0;

  issue_scoreboard #(.NREGS(NREGS), .RIDX_W(RIDX_W)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (set_en),
    .set_idx   (rd),
    .clr_en    (clr_en),
    .clr_idx   (bus.wb_rd),
    .rs1_idx   (rs1),
    .rs2_idx   (rs2),
    .rd_idx    (rd),
    .rs1_pend  (rs1_pend),
    .rs2_pend  (rs2_pend),
    .rd_pend   (rd_pend),
    .pend_next (pend_next)
  );

  // Hazard of whatever sits in the buffer after this edge, judged against the
  // scoreboard after this edge, so STALL means "blocked" from its first cycle.
  // pend_next[0] is always 0, which makes the x0 exclusion implicit here.
  assign next_instr = accept ? bus.if_instr : instr_q;
  assign next_use   = decode_use(next_instr[6:2]);
  assign next_hz    = (next_use.use_rs1 && pend_next[next_instr[19:15]]) ||
                      (next_use.use_rs2 && pend_next[next_instr[24:20]]) ||
                      (next_use.use_rd  && pend_next[next_instr[11:7]]);

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = next_hz ? ST_STALL : ST_HOLD;
      ST_HOLD, ST_STALL: begin
        if (bus.flush || (issue && !accept)) state_d = ST_EMPTY;
        else                                 state_d = next_hz ? ST_STALL : ST_HOLD;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Instruction buffer, loaded on every accepted fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instr_q <= '0;
    else if (accept) instr_q <= bus.if_instr;
  end

  // Saturating count of cycles spent in STALL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      stall_cnt <= '0;
    else if (state_q == ST_STALL && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl: hazard stalls, writeback release,
// flush, set/clear collision and execute back-pressure.
module tb_decode_issue_ctrl;
  import decode_issue_ctrl_pkg::*;

  logic               clk;
  logic               rst_n;
  logic [STALL_W-1:0] stall_cnt;
  int                 total;
  int                 bad;

  decode_issue_ctrl_if bus();

  decode_issue_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] s_sw(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'b0, rs2, rs1, 3'b010, 5'b0, 7'b0100011};
  endfunction

  function automatic logic [31:0] u_lui(input logic [4:0] rd);
    return {20'h12345, rd, 7'b0110111};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_reset;
    rst_n        = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_instr = '0;
    bus.ex_ready = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_rd    = '0;
    bus.flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    total++; if (bus.if_ready !== 1'b1) begin bad++; $display("FAIL rst_if_ready got=%0b want=1", bus.if_ready); end
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL rst_ex_valid got=%0b want=0", bus.ex_valid); end
    total++; if (bus.ex_instr !== 32'h0) begin bad++; $display("FAIL rst_ex_instr got=%h want=0", bus.ex_instr); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_stall_cnt got=%0d want=0", stall_cnt); end
    bus.if_valid = 1'b1;
    bus.if_instr = r_add(5'd5, 5'd1, 5'd2);
    step();
    bus.if_valid = 1'b0;
    settle();
    total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid got=%0b want=1", bus.ex_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid got=%0b want=0", bus.ex_valid); end
    total++; if (bus.ex_instr !== 32'h0) begin bad++; $display("FAIL rst_async_instr got=%h want=0", bus.ex_instr); end
  endtask

  task automatic test_raw_stall;
    logic [31:0] i1, i2;
    i1 = r_add(5'd5, 5'd1, 5'd2);
    i2 = r_add(5'd6, 5'd5, 5'd3);
    do_reset();
    bus.ex_ready = 1'b1;
    bus.if_valid = 1'b1;
    bus.if_instr = i1;
    step();
    settle();
    total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL raw_i1_valid got=%0b want=1", bus.ex_valid); end
    total++; if (bus.ex_instr !== i1) begin bad++; $display("FAIL raw_i1_instr got=%h want=%h", bus.ex_instr, i1); end
    bus.if_instr = i2;
    step();
    bus.if_valid = 1'b0;
    settle();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL raw_i2_stall got=%0b want=0", bus.ex_valid); end
    total++; if (bus.ex_instr !== i2) begin bad++; $display("FAIL raw_i2_instr got=%h want=%h", bus.ex_instr, i2); end
    total++; if (bus.if_ready !== 1'b0) begin bad++; $display("FAIL raw_if_ready got=%0b want=0", bus.if_ready); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL raw_cnt0 got=%0d want=0", stall_cnt); end
    repeat (3) step();
    settle();
    total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL raw_cnt3 got=%0d want=3", stall_cnt); end
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL raw_still_stall got=%0b want=0", bus.ex_valid); end
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    settle();
`ifdef ISSUE_BYPASS_EN
    total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL raw_wb_cycle got=%0b want=1", bus.ex_valid); end
`else
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL raw_wb_cycle got=%0b want=0", bus.ex_valid); end
`endif
    step();
    bus.wb_valid = 1'b0;
    settle();
    total++; if (stall_cnt !== 16'd4) begin bad++; $display("FAIL raw_cnt4 got=%0d want=4", stall_cnt); end
`ifdef ISSUE_BYPASS_EN
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL raw_after_wb got=%0b want=0", bus.ex_valid); end
    total++; if (bus.if_ready !== 1'b1) begin bad++; $display("FAIL raw_empty_ready got=%0b want=1", bus.if_ready); end
`else
    total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL raw_after_wb got=%0b want=1", bus.ex_valid); end
    step();
    settle();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL raw_issued got=%0b want=0", bus.ex_valid); end
    total++; if (stall_cnt !== 16'd4) begin bad++; $display("FAIL raw_cnt_hold got=%0d want=4", stall_cnt); end
`endif
  endtask

  task automatic test_store_waw_flush;
    logic [31:0] l5, sw, l0, a8;
    l5 = u_lui(5'd5);
    sw = s_sw(5'd5, 5'd1);
    l0 = u_lui(5'd0);
    a8 = r_add(5'd8, 5'd0, 5'd0);
    do_reset();
    bus.ex_ready = 1'b1;
    bus.if_valid = 1'b1;
    bus.if_instr = l5;
    step();
    settle();
    total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL sw_lui_valid got=%0b want=1", bus.ex_valid); end
    bus.if_instr = sw;
    step();
    settle();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL sw_stall got=%0b want=0", bus.ex_valid); end
    total++; if (bus.ex_instr !== sw) begin bad++; $display("FAIL sw_instr got=%h want=%h", bus.ex_instr, sw); end
    bus.flush    = 1'b1;
    bus.if_instr = l5;
    settle();
    total++; if (bus.if_ready !== 1'b0) begin bad++; $display("FAIL flush_if_ready got=%0b want=0", bus.if_ready); end
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL flush_ex_valid got=%0b want=0", bus.ex_valid); end
    step();
    bus.flush = 1'b0;
    settle();
    total++; if (bus.if_ready !== 1'b1) begin bad++; $display("FAIL flush_empty_ready got=%0b want=1", bus.if_ready); end
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL flush_empty_valid got=%0b want=0", bus.ex_valid); end
    step();
    settle();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL waw_stall got=%0b want=0", bus.ex_valid); end
    total++; if (bus.ex_instr !== l5) begin bad++; $display("FAIL waw_instr got=%h want=%h", bus.ex_instr, l5); end
    bus.flush    = 1'b1;
    bus.if_valid = 1'b0;
    step();
    bus.flush    = 1'b0;
    bus.if_valid = 1'b1;
    bus.if_instr = l0;
    step();
    settle();
    total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL lui_x0_valid got=%0b want=1", bus.ex_valid); end
    bus.if_instr = a8;
    step();
    bus.if_valid = 1'b0;
    settle();
    total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%0b want=1", bus.ex_valid); end
    total++; if (bus.ex_instr !== a8) begin bad++; $display("FAIL b2b_instr got=%h want=%h", bus.ex_instr, a8); end
    total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL sw_cnt got=%0d want=2", stall_cnt); end
  endtask

  task automatic test_set_clear_collision;
    logic [31:0] a7, d9;
    a7 = r_add(5'd7, 5'd1, 5'd2);
    d9 = r_add(5'd9, 5'd7, 5'd0);
    do_reset();
    bus.ex_ready = 1'b1;
    bus.if_valid = 1'b1;
    bus.if_instr = a7;
    step();
    bus.if_instr = d9;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd7;
    settle();
    total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL col_a7_valid got=%0b want=1", bus.ex_valid); end
    step();
    bus.wb_valid = 1'b0;
    bus.if_valid = 1'b0;
    settle();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL col_set_wins got=%0b want=0", bus.ex_valid); end
    total++; if (bus.ex_instr !== d9) begin bad++; $display("FAIL col_instr got=%h want=%h", bus.ex_instr, d9); end
    step();
    settle();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL col_still got=%0b want=0", bus.ex_valid); end
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL col_cnt got=%0d want=1", stall_cnt); end
  endtask

  task automatic test_back_pressure;
    logic [31:0] b, c;
    b = r_add(5'd10, 5'd1, 5'd2);
    c = r_add(5'd11, 5'd1, 5'd2);
    do_reset();
    bus.ex_ready = 1'b0;
    bus.if_valid = 1'b1;
    bus.if_instr = b;
    step();
    bus.if_instr = c;
    for (int k = 0; k < 4; k++) begin
      settle();
      total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%0b want=1", k, bus.ex_valid); end
      total++; if (bus.ex_instr !== b) begin bad++; $display("FAIL bp_instr[%0d] got=%h want=%h", k, bus.ex_instr, b); end
      total++; if (bus.if_ready !== 1'b0) begin bad++; $display("FAIL bp_if_ready[%0d] got=%0b want=0", k, bus.if_ready); end
      step();
    end
    bus.ex_ready = 1'b1;
    settle();
    total++; if (bus.if_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%0b want=1", bus.if_ready); end
    step();
    bus.if_valid = 1'b0;
    settle();
    total++; if (bus.ex_instr !== c) begin bad++; $display("FAIL bp_next_instr got=%h want=%h", bus.ex_instr, c); end
    total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL bp_next_valid got=%0b want=1", bus.ex_valid); end
    step();
    settle();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%0b want=0", bus.ex_valid); end
    total++; if (bus.if_ready !== 1'b1) begin bad++; $display("FAIL bp_empty_ready got=%0b want=1", bus.if_ready); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_raw_stall();
    test_store_waw_flush();
    test_set_clear_collision();
    test_back_pressure();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
